// File: rtl/uart_frame_pkg.sv
// Shared types and elaboration helpers for the UART frame transmitter.
package uart_frame_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} tx_state_e;

  typedef enum logic [1:0] {SlotHdr, SlotPay, SlotCsum} slot_e;

  function automatic int unsigned calc_bit_clks(int unsigned clkfreq, int unsigned baud);
    return clkfreq / baud;
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic slot_e byte_slot(int unsigned idx, logic hdr_en, int unsigned nbytes);
    if (hdr_en && idx == 0) return SlotHdr;
    if (idx >= nbytes + 32'(hdr_en)) return SlotCsum;
    return SlotPay;
  endfunction

endpackage

// File: rtl/uart_frame_tx_ser.sv
// Single-byte serializer: start bit, 8 data bits LSB first, STOP_BITS stop bits.
module uart_byte_ser
  import uart_frame_pkg::*;
#(
  parameter int unsigned BIT_CLKS  = 10,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       done,
  output logic       txd
);

  localparam int unsigned ClkW  = cnt_width(BIT_CLKS);
  localparam int unsigned NBits = 9 + STOP_BITS;
  localparam int unsigned BitW  = cnt_width(NBits);
  localparam logic [ClkW-1:0] ClkLast = ClkW'(BIT_CLKS - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(NBits - 1);

  logic            active_q;
  logic            txd_q;
  logic [ClkW-1:0] clk_cnt_q;
  logic [BitW-1:0] bit_cnt_q;
  logic [7:0]      shift_q;
  logic            bit_end;

  assign bit_end = active_q && (clk_cnt_q == ClkLast);
  assign done    = bit_end && (bit_cnt_q == BitLast);
  assign ready   = !active_q;
  assign txd     = txd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= 1'b0;
      txd_q     <= 1'b1;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (start && !active_q) begin
      active_q  <= 1'b1;
      txd_q     <= 1'b0;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= data;
    end else if (active_q) begin
      if (!bit_end) begin
        clk_cnt_q <= clk_cnt_q + ClkW'(1);
      end else begin
        clk_cnt_q <= '0;
        if (done) begin
          active_q <= 1'b0;
          txd_q    <= 1'b1;
        end else begin
          // Ones shift in behind the data so the stop bits fall out naturally.
          bit_cnt_q <= bit_cnt_q + BitW'(1);
          txd_q     <= shift_q[0];
          shift_q   <= {1'b1, shift_q[7:1]};
        end
      end
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Snapshots NBYTES of parallel data and sends them as one UART frame with optional
// header and XOR checksum, started by trig or an internal periodic timer.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLKFREQ     = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned NBYTES      = 8,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned GAP_BITS    = 0,
  parameter int unsigned HDR_EN      = 0,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter int unsigned CSUM_EN     = 0,
  parameter int unsigned AUTO_EN     = 1,
  parameter int unsigned INIT_DELAY  = CLKFREQ,
  parameter int unsigned PERIOD_CLKS = CLKFREQ
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trig,
  input  logic [8*NBYTES-1:0] data_in,
  output logic                UART_tx,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);

  localparam int unsigned BitClks = calc_bit_clks(CLKFREQ, BAUD);
  localparam int unsigned HdrN    = (HDR_EN != 0) ? 1 : 0;
  localparam int unsigned CsumN   = (CSUM_EN != 0) ? 1 : 0;
  localparam int unsigned NSlots  = HdrN + NBYTES + CsumN;
  localparam int unsigned IdxW    = cnt_width(NBYTES + 2);
  localparam int unsigned GapClks = GAP_BITS * BitClks;
  localparam int unsigned GapW    = cnt_width(GapClks);
  localparam int unsigned TmrMax  = (INIT_DELAY > PERIOD_CLKS) ? INIT_DELAY : PERIOD_CLKS;
  localparam int unsigned TmrW    = cnt_width(TmrMax);

  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NSlots - 1);
  // The LOAD cycle counts as one of the idle gap cycles.
  localparam logic [GapW-1:0] GapLast  = GapW'((GapClks >= 2) ? GapClks - 2 : 0);
  localparam logic [TmrW-1:0] InitLast = TmrW'(INIT_DELAY - 1);
  localparam logic [TmrW-1:0] PerLast  = TmrW'(PERIOD_CLKS - 1);

  if (BitClks < 2) begin : g_bad_baud
    $error("uart_frame_tx: CLKFREQ/BAUD must be at least 2");
  end
  if (NBYTES < 1 || NBYTES > 64) begin : g_bad_nbytes
    $error("uart_frame_tx: NBYTES must be 1..64");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_frame_tx: STOP_BITS must be 1 or 2");
  end
  if (GAP_BITS > 15) begin : g_bad_gap
    $error("uart_frame_tx: GAP_BITS must be 0..15");
  end

  tx_state_e           state_q;
  logic [IdxW-1:0]     idx_q;
  logic [GapW-1:0]     gap_q;
  logic [8*NBYTES-1:0] snap_q;
  logic [7:0]          csum_q, csum_d;
  logic                busy_q, frame_done_q, overrun_q;
  logic [TmrW-1:0]     tmr_q;
  logic                init_done_q;
  logic                tick, start_evt;
  logic                ser_start, ser_ready, ser_done;
  logic [7:0]          ser_byte;

  assign tick      = (AUTO_EN != 0) && (init_done_q ? (tmr_q == PerLast) : (tmr_q == InitLast));
  assign start_evt = trig || tick;
  assign ser_start = (state_q == StLoad) && ser_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q       <= '0;
      init_done_q <= 1'b0;
    end else if (tick || (AUTO_EN == 0 && tmr_q == (init_done_q ? PerLast : InitLast))) begin
      tmr_q       <= '0;
      init_done_q <= 1'b1;
    end else begin
      tmr_q <= tmr_q + TmrW'(1);
    end
  end

  always_comb begin
    csum_d = '0;
    for (int unsigned i = 0; i < NBYTES; i++) csum_d ^= data_in[8*i +: 8];
  end

  always_comb begin
    ser_byte = HDR_BYTE;
    unique case (byte_slot(32'(idx_q), HdrN != 0, NBYTES))
      SlotHdr:  ser_byte = HDR_BYTE;
      SlotPay: begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (32'(idx_q) == i + HdrN) ser_byte = snap_q[8*i +: 8];
        end
      end
      SlotCsum: ser_byte = csum_q;
      default:  ser_byte = HDR_BYTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      gap_q        <= '0;
      snap_q       <= '0;
      csum_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      overrun_q    <= start_evt && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (start_evt) begin
            snap_q  <= data_in;
            csum_q  <= csum_d;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: state_q <= StSend;
        StSend: begin
          if (ser_done) begin
            if (idx_q == LastIdx) begin
              state_q      <= StIdle;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IdxW'(1);
              if (GapClks == 0) begin
                state_q <= StLoad;
              end else begin
                gap_q   <= '0;
                state_q <= StGap;
              end
            end
          end
        end
        StGap: begin
          if (gap_q == GapLast) state_q <= StLoad;
          else gap_q <= gap_q + GapW'(1);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  uart_byte_ser #(
    .BIT_CLKS  (BitClks),
    .STOP_BITS (STOP_BITS)
  ) u_ser (
    .clk   (clk),
    .rst   (rst),
    .start (ser_start),
    .data  (ser_byte),
    .ready (ser_ready),
    .done  (ser_done),
    .txd   (UART_tx)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Parametrised periodic/triggered UART frame transmitter.
- Snapshots NBYTES of packed parallel data and serialises them as one frame: optional header byte, payload, optional XOR checksum.
- Sits between register/status logic and the board UART pin.
- Replaces fixed 8-byte status senders. Adds:
  - a data snapshot, so data is stable for the whole frame;
  - configurable byte count, stop bits and inter-byte gap;
  - trigger mode and overrun reporting.

Parameters:
- CLKFREQ, 50000000: clock frequency in Hz.
- BAUD, 115200: bit rate. BIT_CLKS = CLKFREQ/BAUD (integer divide) must be >= 2; elaboration error otherwise.
- NBYTES, 8: payload bytes, 1..64.
- STOP_BITS, 1: stop bits, 1 or 2.
- GAP_BITS, 0: idle bit-times between consecutive bytes of one frame, 0..15.
- HDR_EN, 0: 1 sends HDR_BYTE before the payload.
- HDR_BYTE, 8'hA5: header value.
- CSUM_EN, 0: 1 appends the XOR of all payload bytes (header excluded).
- AUTO_EN, 1: 1 enables the internal periodic start timer.
- INIT_DELAY, CLKFREQ: clocks from reset release to the first periodic start.
- PERIOD_CLKS, CLKFREQ: clocks between periodic starts. Must exceed frame length.

Ports:
- clk, input, 1: sole clock.
- rst, input, 1: synchronous reset, active-high.
- trig, input, 1: one-cycle start request, used in any mode.
- data_in, input, 8*NBYTES: payload. Byte i = data_in[8i+7:8i]; byte 0 is sent first.
- UART_tx, output, 1: serial line, idle high.
- busy, output, 1: frame in progress.
- frame_done, output, 1: one-cycle pulse when the last stop bit completes.
- overrun, output, 1: one-cycle pulse when a start event is dropped.

Behaviour:
- Reset (sampled high at a clk edge):
  - outputs: UART_tx=1, busy=0, frame_done=0, overrun=0;
  - FSM to IDLE; timer to 0.
  - Mid-frame reset aborts immediately: the line is high after that edge and no frame_done is issued.
- Start event: trig=1, or timer tick (AUTO_EN=1).
  - A coincident trig and tick count as a single start.
- Timer:
  - Counts from 0 after reset; tick when count == INIT_DELAY-1.
  - Thereafter a tick every PERIOD_CLKS clocks.
  - Free-runs regardless of busy.
- Start event while IDLE, accepted at edge k:
  - data_in captured into a snapshot register at edge k;
  - busy=1 after edge k;
  - UART_tx=0 (start bit) after edge k+1.
- Start event while busy:
  - dropped; overrun=1 for exactly one cycle after that edge;
  - the current frame is unaffected.
- Byte format:
  - start bit 0, 8 data bits LSB first, STOP_BITS stop bits of 1;
  - each bit held exactly BIT_CLKS cycles.
- Frame order: [HDR_BYTE], snapshot byte 0..NBYTES-1, [checksum].
  - Between consecutive bytes: GAP_BITS*BIT_CLKS idle-high cycles.
  - No gap after the last byte.
- Checksum: XOR of the snapshot bytes only, computed at snapshot time.
- FSM states:
  - IDLE -> LOAD on an accepted start.
  - LOAD (1 cycle: select byte, strobe serializer) -> SEND.
  - SEND -> GAP on byte done when more bytes remain and GAP_BITS>0.
  - SEND -> LOAD on byte done when more bytes remain and GAP_BITS=0. The next start bit follows the previous stop bit by one LOAD cycle; this cycle is part of the line idle time.
  - SEND -> IDLE on last byte done: frame_done=1 and busy=0 after that same edge.
  - GAP -> LOAD when the gap count expires.
- A start event in the cycle busy falls is accepted normally; there is no lockout cycle.
- Byte index counter width: clog2(NBYTES+2). Bit-clock counter width: clog2(BIT_CLKS). No wrap occurs within a frame.
- data_in changes after the snapshot have no effect on the current frame.

Decomposition:
- Package uart_frame_pkg:
  - BIT_CLKS and counter width functions (clog2-based);
  - FSM state encoding (IDLE, LOAD, SEND, GAP);
  - a byte-slot select function (header/payload/checksum).
- Sub-module uart_byte_ser: single-byte serializer.
  - Ports: clk, rst, start, data[7:0], ready, done (pulse), txd.
  - Parameters: BIT_CLKS, STOP_BITS.
  - Owns the bit-clock and bit counters.
- The top level owns the timer, snapshot, checksum, byte sequencing and overrun.

Test Plan:
(Bench parameters: CLKFREQ=1000, BAUD=100 so BIT_CLKS=10; NBYTES=3.)
1. AUTO_EN=0, HDR_EN=1, CSUM_EN=1, GAP_BITS=1, data_in=24'h3C1201, trig pulse at cycle 5 -> line decodes A5,01,12,3C,2F. Each byte is 100 clocks with 10 idle clocks between. busy rises after edge 5, UART_tx falls after edge 6, frame_done pulses once.
2. Change data_in to 24'hFFFFFF one cycle after the trig of scenario 1 -> transmitted bytes unchanged (01,12,3C, checksum 2F).
3. AUTO_EN=1, INIT_DELAY=50, PERIOD_CLKS=600, HDR_EN=CSUM_EN=0, GAP_BITS=0 -> first start bit at cycle 51, next frame 600 cycles later; overrun never asserts.
4. Frame in progress, trig pulsed at mid-frame -> overrun is a one-cycle pulse, frame completes intact, no second frame follows.
5. rst asserted during the data bits of byte 1 -> UART_tx=1 and busy=0 after that edge, no frame_done. A trig after release gives a clean full frame.
6. STOP_BITS=2, data 8'h00 (NBYTES=1) -> line low for 90 clocks, then high for 20; frame_done pulses at the end of the second stop bit.
